// File: rtl/sdram_clk_supervisor.sv
// SDRAM PLL supervisor: PLL reset, filtered lock wait, SDRAM power-up delay, then RUN
// with phase-aligned per-channel clock-enable pulse trains; bounded retries on lock loss.
module sdram_clk_supervisor #(
   parameter int NUM_CH       = 2,
   parameter int DIV_W        = 8,
   parameter int DEF_DIV      = 0,
   parameter int RST_HOLD     = 8,
   parameter int LOCK_FILTER  = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int PWRUP_CYCLES = 20000,
   parameter int RETRY_MAX    = 3
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 pll_locked,
   output logic                                                 pll_rst,
   output logic                                                 sdram_rst,
   output logic                                                 ready,
   output logic                                                 fail,
   output logic [((RETRY_MAX < 3) ? 2 : $clog2(RETRY_MAX+1))-1:0] retry_cnt,
   input  logic [NUM_CH*DIV_W-1:0]                              cfg_div,
   input  logic [NUM_CH*DIV_W-1:0]                              cfg_phase,
   input  logic                                                 cfg_wr,
   output logic [NUM_CH-1:0]                                    ce
);

   localparam int RC_W    = (RETRY_MAX < 3) ? 2 : $clog2(RETRY_MAX+1);
   localparam int MAX_A   = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
   localparam int MAX_CNT = (MAX_A > PWRUP_CYCLES) ? MAX_A : PWRUP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT+1);
   localparam int FLT_W   = $clog2(LOCK_FILTER+1);

   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD-1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT-1);
   localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(PWRUP_CYCLES-1);
   localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(LOCK_FILTER-1);
   localparam logic [RC_W-1:0]  RETRY_LAST = RC_W'(RETRY_MAX-1);

   typedef enum logic [2:0] {
      ST_PLL_RST, ST_WAIT_LOCK, ST_PWRUP, ST_RUN, ST_FAIL
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FLT_W-1:0] filt_q, filt_d;
   logic [RC_W-1:0]  retry_q, retry_d;
   logic             lk_meta_q, lk_q;
   logic             ready_q, sdram_rst_q;
   logic             attempt_fail;
   logic             run_keep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         filt_q      <= '0;
         retry_q     <= '0;
         lk_meta_q   <= 1'b0;
         lk_q        <= 1'b0;
         ready_q     <= 1'b0;
         sdram_rst_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         filt_q      <= filt_d;
         retry_q     <= retry_d;
         lk_meta_q   <= pll_locked;
         lk_q        <= lk_meta_q;
         // ready/sdram_rst follow RUN one cycle late and drop on the edge after lock loss
         ready_q     <= (state_q == ST_RUN) && lk_q;
         sdram_rst_q <= !((state_q == ST_RUN) && lk_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      filt_d       = filt_q;
      retry_d      = retry_q;
      attempt_fail = 1'b0;
      case (state_q)
         ST_PLL_RST: begin
            filt_d = '0;
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            filt_d = lk_q ? filt_q + 1'b1 : '0;
            cnt_d  = cnt_q + 1'b1;
            // lock acceptance takes priority over a coincident timeout
            if (lk_q && (filt_q == FLT_LAST)) begin
               state_d = ST_PWRUP;
               cnt_d   = '0;
               filt_d  = '0;
            end else if (cnt_q == TO_LAST) begin
               attempt_fail = 1'b1;
            end
         end
         ST_PWRUP: begin
            if (!lk_q) begin
               attempt_fail = 1'b1;
            end else if (cnt_q == PW_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!lk_q) attempt_fail = 1'b1;
         end
         ST_FAIL: begin
         end
         default: state_d = ST_PLL_RST;
      endcase
      if (attempt_fail) begin
         retry_d = retry_q + 1'b1;
         cnt_d   = '0;
         filt_d  = '0;
         state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_PLL_RST;
      end
   end

   always_comb begin
      pll_rst   = (state_q == ST_PLL_RST) || (state_q == ST_FAIL);
      fail      = (state_q == ST_FAIL);
      ready     = ready_q;
      sdram_rst = sdram_rst_q;
      retry_cnt = retry_q;
   end

   // counters only advance while RUN continues; any exit or cfg_wr parks them at 0
   assign run_keep = (state_q == ST_RUN) && (state_d == ST_RUN);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] div_q, phase_q, ccnt_q, ccnt_d, eff_phase;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            div_q   <= DIV_W'(DEF_DIV);
            phase_q <= '0;
            ccnt_q  <= '0;
         end else begin
            if (cfg_wr) begin
               div_q   <= cfg_div[gi*DIV_W +: DIV_W];
               phase_q <= cfg_phase[gi*DIV_W +: DIV_W];
            end
            ccnt_q <= ccnt_d;
         end
      end

      always_comb begin
         eff_phase = (phase_q > div_q) ? div_q : phase_q;
         ccnt_d    = '0;
         if (run_keep && !cfg_wr) begin
            ccnt_d = (ccnt_q >= div_q) ? '0 : ccnt_q + 1'b1;
         end
      end

      assign ce[gi] = (state_q == ST_RUN) && (ccnt_q == eff_phase);
   end

endmodule

// File: tb/tb_sdram_clk_supervisor.sv
// Bench for sdram_clk_supervisor: cycle-stamped expectations in a scoreboard queue,
// checked as each cycle completes; CE configurations come from a vector table.
module tb_sdram_clk_supervisor;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: long timeout, used for nominal / glitch / lock-drop / CE / reset tests
   logic        rst_n, pll_locked, cfg_wr;
   logic [23:0] cfg_div, cfg_phase;
   logic        pll_rst, sdram_rst, ready, fail;
   logic [1:0]  retry_cnt;
   logic [2:0]  ce;

   // DUT B: short timeout, lock never asserts
   logic        rst_nb, locked_b, cfg_wr_b;
   logic [23:0] cfg_div_b, cfg_phase_b;
   logic        pll_rst_b, sdram_rst_b, ready_b, fail_b;
   logic [1:0]  retry_b;
   logic [2:0]  ce_b;

   sdram_clk_supervisor #(
      .NUM_CH(3), .DIV_W(8), .DEF_DIV(0), .RST_HOLD(8), .LOCK_FILTER(16),
      .LOCK_TIMEOUT(4096), .PWRUP_CYCLES(100), .RETRY_MAX(3)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .sdram_rst(sdram_rst), .ready(ready), .fail(fail),
      .retry_cnt(retry_cnt), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
      .cfg_wr(cfg_wr), .ce(ce)
   );

   sdram_clk_supervisor #(
      .NUM_CH(3), .DIV_W(8), .DEF_DIV(0), .RST_HOLD(8), .LOCK_FILTER(16),
      .LOCK_TIMEOUT(64), .PWRUP_CYCLES(100), .RETRY_MAX(3)
   ) dut_b (
      .clk(clk), .rst_n(rst_nb), .pll_locked(locked_b),
      .pll_rst(pll_rst_b), .sdram_rst(sdram_rst_b), .ready(ready_b), .fail(fail_b),
      .retry_cnt(retry_b), .cfg_div(cfg_div_b), .cfg_phase(cfg_phase_b),
      .cfg_wr(cfg_wr_b), .ce(ce_b)
   );

   typedef enum int {
      S_PLLRST, S_SDRST, S_READY, S_FAIL, S_RETRY, S_CE,
      S_B_PLLRST, S_B_READY, S_B_FAIL, S_B_RETRY
   } sig_e;

   typedef struct {
      int    cyc;
      sig_e  sig;
      int    val;
      string name;
   } exp_t;

   typedef struct {
      logic [23:0] div;    // ch2 | ch1 | ch0
      logic [23:0] phase;
      logic [29:0] pat;    // per channel, bit k = ce expected k cycles after realign
   } ce_vec_t;

   exp_t    sbq[$];
   ce_vec_t tbl[3];
   int      cyc;
   int      n_checks = 0;
   int      n_pass   = 0;

   function automatic int sample(sig_e s);
      case (s)
         S_PLLRST:   return int'(pll_rst);
         S_SDRST:    return int'(sdram_rst);
         S_READY:    return int'(ready);
         S_FAIL:     return int'(fail);
         S_RETRY:    return int'(retry_cnt);
         S_CE:       return int'(ce);
         S_B_PLLRST: return int'(pll_rst_b);
         S_B_READY:  return int'(ready_b);
         S_B_FAIL:   return int'(fail_b);
         S_B_RETRY:  return int'(retry_b);
         default:    return -1;
      endcase
   endfunction

   task automatic chk(string name, int act, int req);
      n_checks++;
      if (act == req) begin
         n_pass++;
         $display("check %s: got %0d ok", name, act);
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic expect_at(int c, sig_e s, int v, string name);
      sbq.push_back('{c, s, v, name});
   endtask

   task automatic sb_eval();
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc == cyc) begin
            chk($sformatf("%s@%0d", sbq[i].name, cyc), sample(sbq[i].sig), sbq[i].val);
            sbq.delete(i);
         end else if (sbq[i].cyc < cyc) begin
            n_checks++;
            $display("FAIL %s: cycle %0d passed without evaluation, expected %0d",
                     sbq[i].name, sbq[i].cyc, sbq[i].val);
            sbq.delete(i);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      sb_eval();
   endtask

   task automatic run_to(int c);
      while (cyc < c) tick();
   endtask

   task automatic push_pattern(int start, int r, string name);
      logic [2:0] v;
      for (int k = 0; k < 10; k++) begin
         v = {tbl[r].pat[20+k], tbl[r].pat[10+k], tbl[r].pat[k]};
         expect_at(start + k, S_CE, int'(v), name);
      end
   endtask

   task automatic check_reset_values(string tag);
      chk({tag, "_pll_rst"},   int'(pll_rst),   1);
      chk({tag, "_sdram_rst"}, int'(sdram_rst), 1);
      chk({tag, "_ready"},     int'(ready),     0);
      chk({tag, "_fail"},      int'(fail),      0);
      chk({tag, "_retry"},     int'(retry_cnt), 0);
      chk({tag, "_ce"},        int'(ce),        0);
   endtask

   initial begin
      tbl[0] = '{div: {8'd4, 8'd0, 8'd3},   phase: {8'd9, 8'd0, 8'd1},
                 pat: {10'h210, 10'h3FF, 10'h222}};
      tbl[1] = '{div: {8'd255, 8'd2, 8'd1}, phase: {8'd7, 8'd2, 8'd0},
                 pat: {10'h080, 10'h124, 10'h155}};
      tbl[2] = '{div: {8'd2, 8'd5, 8'd0},   phase: {8'd0, 8'd3, 8'd5},
                 pat: {10'h249, 10'h208, 10'h3FF}};

      rst_n = 1'b0; rst_nb = 1'b0; pll_locked = 1'b0; locked_b = 1'b0;
      cfg_wr = 1'b0; cfg_div = '0; cfg_phase = '0;
      cfg_wr_b = 1'b0; cfg_div_b = '0; cfg_phase_b = '0;
      cyc = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      chk("reset_b_pll_rst", int'(pll_rst_b), 1);

      // Nominal start; DUT B runs its timeout/retry sequence alongside
      rst_n = 1'b1; rst_nb = 1'b1; cyc = 0;
      expect_at(1,   S_PLLRST, 1, "nom_pll_rst_hi");
      expect_at(7,   S_PLLRST, 1, "nom_pll_rst_last");
      expect_at(8,   S_PLLRST, 0, "nom_pll_rst_lo");
      expect_at(137, S_CE,     0, "nom_ce_pwrup");
      expect_at(138, S_CE,     7, "nom_ce_run_entry");
      expect_at(138, S_READY,  0, "nom_ready_pre");
      expect_at(138, S_SDRST,  1, "nom_sdram_rst_pre");
      expect_at(139, S_READY,  1, "nom_ready_rise");
      expect_at(139, S_SDRST,  0, "nom_sdram_rst_fall");
      expect_at(139, S_RETRY,  0, "nom_retry");
      expect_at(7,   S_B_PLLRST, 1, "to_pll_rst_a1");
      expect_at(8,   S_B_PLLRST, 0, "to_pll_rst_a1_end");
      expect_at(71,  S_B_RETRY,  0, "to_retry0");
      expect_at(72,  S_B_RETRY,  1, "to_retry1");
      expect_at(72,  S_B_PLLRST, 1, "to_pll_rst_a2");
      expect_at(79,  S_B_PLLRST, 1, "to_pll_rst_a2_last");
      expect_at(80,  S_B_PLLRST, 0, "to_pll_rst_a2_end");
      expect_at(144, S_B_RETRY,  2, "to_retry2");
      expect_at(151, S_B_PLLRST, 1, "to_pll_rst_a3_last");
      expect_at(152, S_B_PLLRST, 0, "to_pll_rst_a3_end");
      expect_at(215, S_B_FAIL,   0, "to_fail_pre");
      expect_at(216, S_B_FAIL,   1, "to_fail");
      expect_at(216, S_B_RETRY,  3, "to_retry3");
      expect_at(216, S_B_PLLRST, 1, "to_pll_rst_fail");
      expect_at(480, S_B_FAIL,   1, "to_fail_hold");
      expect_at(480, S_B_RETRY,  3, "to_retry_hold");
      expect_at(480, S_B_PLLRST, 1, "to_pll_rst_hold");
      expect_at(480, S_B_READY,  0, "to_ready_hold");
      run_to(20);
      pll_locked = 1'b1;

      // CE table: each row written mid-RUN realigns all channels the next cycle
      for (int r = 0; r < 3; r++) begin
         run_to(150 + 20*r);
         cfg_div = tbl[r].div; cfg_phase = tbl[r].phase; cfg_wr = 1'b1;
         push_pattern(cyc + 1, r, $sformatf("ce_row%0d", r));
         tick();
         cfg_wr = 1'b0;
      end

      // Lock drop in RUN at T=250, relock at 280
      run_to(250);
      expect_at(252, S_READY,  1, "drop_ready_hold");
      expect_at(253, S_READY,  0, "drop_ready_fall");
      expect_at(253, S_SDRST,  1, "drop_sdram_rst");
      expect_at(253, S_RETRY,  1, "drop_retry1");
      expect_at(253, S_PLLRST, 1, "drop_pll_rst");
      expect_at(253, S_CE,     0, "drop_ce_off");
      expect_at(260, S_PLLRST, 1, "drop_pll_rst_last");
      expect_at(261, S_PLLRST, 0, "drop_pll_rst_end");
      pll_locked = 1'b0;
      run_to(280);
      pll_locked = 1'b1;
      expect_at(397, S_RETRY, 1, "relock_retry_pre");
      expect_at(398, S_RETRY, 0, "relock_retry_clr");
      expect_at(398, S_READY, 0, "relock_ready_pre");
      expect_at(399, S_READY, 1, "relock_ready");
      expect_at(399, S_SDRST, 0, "relock_sdram_rst");
      run_to(481);

      // DUT B leaves FAIL only through rst_n
      rst_nb = 1'b0;
      #1;
      chk("to_rst_fail",    int'(fail_b),    0);
      chk("to_rst_retry",   int'(retry_b),   0);
      chk("to_rst_pll_rst", int'(pll_rst_b), 1);

      // Glitchy lock: toggles every 5 cycles for 200 cycles, then steady
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; cyc = 0;
      expect_at(200, S_READY, 0, "glitch_ready");
      expect_at(200, S_SDRST, 1, "glitch_sdram_rst");
      expect_at(200, S_RETRY, 0, "glitch_retry");
      expect_at(200, S_PLLRST, 0, "glitch_pll_rst");
      expect_at(317, S_CE,    0, "glitch_ce_pwrup");
      expect_at(318, S_READY, 0, "glitch_ready_pre");
      expect_at(319, S_READY, 1, "glitch_ready_rise");
      expect_at(319, S_RETRY, 0, "glitch_retry_run");
      push_pattern(318, 0, "glitch_ce_row0");
      while (cyc < 200) begin
         pll_locked = ((cyc / 5) % 2) == 0;
         if (cyc == 100) begin
            cfg_div = tbl[0].div; cfg_phase = tbl[0].phase; cfg_wr = 1'b1;
         end else begin
            cfg_wr = 1'b0;
         end
         tick();
      end
      cfg_wr = 1'b0;
      pll_locked = 1'b1;
      run_to(330);

      // Reset pulse during PWRUP (cycle 60) discards sequence and config
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; cyc = 0;
      expect_at(7,  S_PLLRST, 1, "pre_pll_rst_last");
      expect_at(8,  S_PLLRST, 0, "pre_pll_rst_end");
      expect_at(59, S_PLLRST, 0, "pre_pwrup_pll_rst");
      expect_at(59, S_READY,  0, "pre_pwrup_ready");
      run_to(40);
      cfg_div = tbl[1].div; cfg_phase = tbl[1].phase; cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
      run_to(60);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async");
      tick();
      rst_n = 1'b1; cyc = 0;
      expect_at(7,   S_PLLRST, 1, "rst2_pll_rst_last");
      expect_at(8,   S_PLLRST, 0, "rst2_pll_rst_end");
      expect_at(123, S_CE,     0, "rst2_ce_pwrup");
      expect_at(124, S_CE,     7, "rst2_ce_entry");
      expect_at(125, S_CE,     7, "rst2_ce_default_div");
      expect_at(124, S_READY,  0, "rst2_ready_pre");
      expect_at(125, S_READY,  1, "rst2_ready");
      expect_at(125, S_SDRST,  0, "rst2_sdram_rst");
      run_to(130);

      foreach (sbq[i]) begin
         n_checks++;
         $display("FAIL %s: cycle %0d never reached, expected %0d", sbq[i].name, sbq[i].cyc, sbq[i].val);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
